// File: rtl/usbf_trn_seq_pkg.sv
// Shared encodings and widths for the USB function transaction sequencer.
package usbf_trn_seq_pkg;
  localparam int unsigned NUM_EP  = 16;
  localparam int unsigned EP_W    = 4;
  localparam int unsigned FADR_W  = 7;
  localparam int unsigned TMR_W   = 8;
  localparam int unsigned STATE_W = 6;

  localparam logic [STATE_W-1:0] ST_IDLE      = 6'b000001;
  localparam logic [STATE_W-1:0] ST_WAIT_DATA = 6'b000010;
  localparam logic [STATE_W-1:0] ST_RX_DATA   = 6'b000100;
  localparam logic [STATE_W-1:0] ST_HS        = 6'b001000;
  localparam logic [STATE_W-1:0] ST_TX_DATA   = 6'b010000;
  localparam logic [STATE_W-1:0] ST_WAIT_ACK  = 6'b100000;

  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b01;
  localparam logic [1:0] HS_STALL = 2'b10;

  localparam logic [TMR_W-1:0] TO_CYCLES_DEF = 8'd60;

  // Handshake reflecting endpoint status only: halted, not ready, or ready.
  function automatic logic [1:0] hs_status(input logic stall, input logic rdy);
    if (stall) return HS_STALL;
    return rdy ? HS_ACK : HS_NAK;
  endfunction
endpackage

// File: rtl/usbf_seq_timer.sv
// Bus-turnaround counter: clear has priority, counts while enabled,
// saturates at all-ones and flags the terminal count.
module usbf_seq_timer
  import usbf_trn_seq_pkg::*;
#(
  parameter logic [TMR_W-1:0] TC = TO_CYCLES_DEF - 8'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);
  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst || clr) count <= '0;
    else if (en && (count != {TMR_W{1'b1}})) count <= count + TMR_W'(1);
  end

  assign tc_c = (count == TC);
endmodule

// File: rtl/usbf_trn_seq.sv
// USB function transaction sequencer: token qualification, OUT/SETUP/IN/PING
// sequencing, per-endpoint data toggles and turnaround timeouts.
module usbf_trn_seq
  import usbf_trn_seq_pkg::*;
#(
  parameter logic [TMR_W-1:0] TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pid_OUT,
  input  logic              pid_IN,
  input  logic              pid_SETUP,
  input  logic              pid_SOF,
  input  logic              pid_PING,
  input  logic              pid_DATA0,
  input  logic              pid_DATA1,
  input  logic              pid_ACK,
  input  logic              pid_cks_err,
  input  logic              token_valid,
  input  logic              crc5_err,
  input  logic [FADR_W-1:0] token_fadr,
  input  logic [EP_W-1:0]   token_endp,
  input  logic              rx_data_done,
  input  logic              crc16_err,
  input  logic              seq_err,
  input  logic [FADR_W-1:0] func_adr,
  input  logic [NUM_EP-1:0] ep_en,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic [NUM_EP-1:0] ep_buf_rdy,
  input  logic [NUM_EP-1:0] ep_toggle_clr,
  input  logic              hs_ack,
  input  logic              tx_data_done,
  output logic              hs_req,
  output logic [1:0]        hs_pid,
  output logic              tx_data_req,
  output logic              tx_data_pid,
  output logic [EP_W-1:0]   ep_sel,
  output logic              rx_dma_en,
  output logic              rx_commit,
  output logic              tx_commit,
  output logic              sof_det,
  output logic              to_err,
  output logic [NUM_EP-1:0] toggle
);
  logic [STATE_W-1:0] state, state_nxt;
  logic               is_setup, is_setup_nxt;
  logic               data_pid, data_pid_nxt;
  logic               hs_req_nxt, tx_data_req_nxt, tx_data_pid_nxt;
  logic [1:0]         hs_pid_nxt;
  logic [EP_W-1:0]    ep_sel_nxt;
  logic               rx_dma_en_nxt, rx_commit_nxt, tx_commit_nxt, sof_det_nxt, to_err_nxt;
  logic [NUM_EP-1:0]  toggle_nxt;
  logic               tok_ok, tgl_set, tgl_flip;
  logic               tmr_en, tmr_tc;

  assign tmr_en = (state == ST_WAIT_DATA) || (state == ST_WAIT_ACK);

  usbf_seq_timer #(.TC(TO_CYCLES - 8'd1)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!tmr_en),
    .en   (tmr_en),
    .tc_c (tmr_tc)
  );

  assign tok_ok = token_valid && !crc5_err && !pid_cks_err &&
                  (token_fadr == func_adr) && ep_en[token_endp];

  // Next-state, registered-output and toggle-bank logic.
  always_comb begin
    state_nxt       = state;
    is_setup_nxt    = is_setup;
    data_pid_nxt    = data_pid;
    hs_req_nxt      = hs_req;
    hs_pid_nxt      = hs_pid;
    tx_data_req_nxt = tx_data_req;
    tx_data_pid_nxt = tx_data_pid;
    ep_sel_nxt      = ep_sel;
    rx_commit_nxt   = 1'b0;
    tx_commit_nxt   = 1'b0;
    to_err_nxt      = 1'b0;
    tgl_set         = 1'b0;
    tgl_flip        = 1'b0;
    sof_det_nxt     = token_valid && pid_SOF && !crc5_err;

    case (state)
      ST_IDLE: begin
        if (tok_ok && (pid_OUT || pid_SETUP)) begin
          state_nxt    = ST_WAIT_DATA;
          ep_sel_nxt   = token_endp;
          is_setup_nxt = pid_SETUP;
        end else if (tok_ok && pid_IN) begin
          ep_sel_nxt = token_endp;
          if (ep_stall[token_endp] || !ep_buf_rdy[token_endp]) begin
            state_nxt  = ST_HS;
            hs_req_nxt = 1'b1;
            hs_pid_nxt = hs_status(ep_stall[token_endp], 1'b0);
          end else begin
            state_nxt       = ST_TX_DATA;
            tx_data_req_nxt = 1'b1;
            tx_data_pid_nxt = toggle[token_endp];
          end
        end else if (tok_ok && pid_PING) begin
          state_nxt  = ST_HS;
          ep_sel_nxt = token_endp;
          hs_req_nxt = 1'b1;
          hs_pid_nxt = hs_status(ep_stall[token_endp], ep_buf_rdy[token_endp]);
        end
      end
      ST_WAIT_DATA: begin
        // A data PID arriving on the terminal-count cycle still wins.
        if (pid_DATA0 || pid_DATA1) begin
          state_nxt    = ST_RX_DATA;
          data_pid_nxt = pid_DATA1;
        end else if (tmr_tc) begin
          state_nxt  = ST_IDLE;
          to_err_nxt = 1'b1;
        end
      end
      ST_RX_DATA: begin
        if (rx_data_done && (crc16_err || seq_err)) begin
          state_nxt = ST_IDLE;
        end else if (rx_data_done) begin
          state_nxt  = ST_HS;
          hs_req_nxt = 1'b1;
          if (is_setup) begin
            hs_pid_nxt    = HS_ACK;
            rx_commit_nxt = 1'b1;
            tgl_set       = 1'b1;
          end else begin
            hs_pid_nxt = hs_status(ep_stall[ep_sel], ep_buf_rdy[ep_sel]);
            // Duplicate packets (toggle mismatch) are ACKed but discarded.
            if (!ep_stall[ep_sel] && ep_buf_rdy[ep_sel] && (data_pid == toggle[ep_sel])) begin
              rx_commit_nxt = 1'b1;
              tgl_flip      = 1'b1;
            end
          end
        end
      end
      ST_HS: begin
        if (hs_ack) begin
          state_nxt  = ST_IDLE;
          hs_req_nxt = 1'b0;
        end
      end
      ST_TX_DATA: begin
        if (tx_data_done) begin
          state_nxt       = ST_WAIT_ACK;
          tx_data_req_nxt = 1'b0;
        end
      end
      ST_WAIT_ACK: begin
        if (token_valid && pid_ACK) begin
          state_nxt     = ST_IDLE;
          tx_commit_nxt = 1'b1;
          tgl_flip      = 1'b1;
        end else if (tmr_tc) begin
          state_nxt  = ST_IDLE;
          to_err_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt       = ST_IDLE;
        hs_req_nxt      = 1'b0;
        tx_data_req_nxt = 1'b0;
      end
    endcase

    rx_dma_en_nxt = (state_nxt == ST_WAIT_DATA) || (state_nxt == ST_RX_DATA);

    toggle_nxt = toggle;
    for (int i = 0; i < NUM_EP; i++) begin
      if (ep_toggle_clr[i]) toggle_nxt[i] = 1'b0;
      else if ((ep_sel == EP_W'(i)) && tgl_set) toggle_nxt[i] = 1'b1;
      else if ((ep_sel == EP_W'(i)) && tgl_flip) toggle_nxt[i] = ~toggle[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      is_setup    <= 1'b0;
      data_pid    <= 1'b0;
      hs_req      <= 1'b0;
      hs_pid      <= 2'b00;
      tx_data_req <= 1'b0;
      tx_data_pid <= 1'b0;
      ep_sel      <= '0;
      rx_dma_en   <= 1'b0;
      rx_commit   <= 1'b0;
      tx_commit   <= 1'b0;
      sof_det     <= 1'b0;
      to_err      <= 1'b0;
      toggle      <= '0;
    end else begin
      state       <= state_nxt;
      is_setup    <= is_setup_nxt;
      data_pid    <= data_pid_nxt;
      hs_req      <= hs_req_nxt;
      hs_pid      <= hs_pid_nxt;
      tx_data_req <= tx_data_req_nxt;
      tx_data_pid <= tx_data_pid_nxt;
      ep_sel      <= ep_sel_nxt;
      rx_dma_en   <= rx_dma_en_nxt;
      rx_commit   <= rx_commit_nxt;
      tx_commit   <= tx_commit_nxt;
      sof_det     <= sof_det_nxt;
      to_err      <= to_err_nxt;
      toggle      <= toggle_nxt;
    end
  end
endmodule

// File: tb/tb_usbf_trn_seq.sv
// Bench for usbf_trn_seq: directed transaction table, corner sequences and
// randomized transactions against a transaction-level toggle/handshake model.
module tb_usbf_trn_seq;
  localparam int K_OUT = 0, K_SETUP = 1, K_IN = 2, K_PING = 3, K_BADADR = 4,
                 K_CRC5 = 5, K_SOF = 6, K_DIS = 7, K_CKS = 8;
  localparam int H_ACK = 0, H_NAK = 1, H_STL = 2, H_NONE = 4;

  logic clk, rst;
  logic pid_OUT, pid_IN, pid_SETUP, pid_SOF, pid_PING, pid_DATA0, pid_DATA1, pid_ACK;
  logic pid_cks_err, token_valid, crc5_err, rx_data_done, crc16_err, seq_err;
  logic [6:0] token_fadr, func_adr;
  logic [3:0] token_endp, ep_sel;
  logic [15:0] ep_en, ep_stall, ep_buf_rdy, ep_toggle_clr, toggle;
  logic hs_ack, tx_data_done, hs_req, tx_data_req, tx_data_pid;
  logic rx_dma_en, rx_commit, tx_commit, sof_det, to_err;
  logic [1:0] hs_pid;

  int n_chk = 0, n_fail = 0;
  int cnt_rxc = 0, cnt_txc = 0, cnt_to = 0, cnt_sof = 0;
  logic [15:0] mt;

  usbf_trn_seq dut (
    .clk(clk), .rst(rst),
    .pid_OUT(pid_OUT), .pid_IN(pid_IN), .pid_SETUP(pid_SETUP), .pid_SOF(pid_SOF),
    .pid_PING(pid_PING), .pid_DATA0(pid_DATA0), .pid_DATA1(pid_DATA1), .pid_ACK(pid_ACK),
    .pid_cks_err(pid_cks_err), .token_valid(token_valid), .crc5_err(crc5_err),
    .token_fadr(token_fadr), .token_endp(token_endp), .rx_data_done(rx_data_done),
    .crc16_err(crc16_err), .seq_err(seq_err), .func_adr(func_adr), .ep_en(ep_en),
    .ep_stall(ep_stall), .ep_buf_rdy(ep_buf_rdy), .ep_toggle_clr(ep_toggle_clr),
    .hs_ack(hs_ack), .tx_data_done(tx_data_done), .hs_req(hs_req), .hs_pid(hs_pid),
    .tx_data_req(tx_data_req), .tx_data_pid(tx_data_pid), .ep_sel(ep_sel),
    .rx_dma_en(rx_dma_en), .rx_commit(rx_commit), .tx_commit(tx_commit),
    .sof_det(sof_det), .to_err(to_err), .toggle(toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_commit) cnt_rxc++;
    if (tx_commit) cnt_txc++;
    if (to_err)    cnt_to++;
    if (sof_det)   cnt_sof++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_tok();
    token_valid = 0; pid_OUT = 0; pid_IN = 0; pid_SETUP = 0; pid_SOF = 0; pid_PING = 0;
    pid_ACK = 0; crc5_err = 0; pid_cks_err = 0;
  endtask

  task automatic send_token(input int kind, input logic [3:0] ep);
    token_valid = 1;
    token_endp  = ep;
    token_fadr  = (kind == K_BADADR) ? 7'h06 : (kind == K_SOF) ? 7'($urandom) : 7'h05;
    crc5_err    = (kind == K_CRC5);
    pid_cks_err = (kind == K_CKS);
    pid_OUT     = (kind == K_OUT);
    pid_SETUP   = (kind == K_SETUP);
    pid_PING    = (kind == K_PING);
    pid_SOF     = (kind == K_SOF);
    pid_IN      = (kind == K_IN) || (kind == K_BADADR) || (kind == K_CRC5) ||
                  (kind == K_CKS) || (kind == K_DIS);
    step();
    clear_tok();
  endtask

  task automatic run_txn(input int kind, input logic [3:0] ep, input logic stall, input logic rdy,
                         input logic dpid, input logic err, input logic ack, input int exp_hs,
                         input logic exp_tx, input logic exp_tpid, input int exp_rxc,
                         input int exp_txc, input int exp_to, input logic [15:0] exp_tgl);
    int rxc0, txc0, to0, sof0, n;
    rxc0 = cnt_rxc; txc0 = cnt_txc; to0 = cnt_to; sof0 = cnt_sof;
    ep_stall[ep] = stall;
    ep_buf_rdy[ep] = rdy;
    send_token(kind, ep);
    if (kind == K_OUT || kind == K_SETUP) begin
      chk("rx_dma_en after token", 32'(rx_dma_en), 32'(1));
      chk("ep_sel latch", 32'(ep_sel), 32'(ep));
      step(int'($urandom_range(0, 4)));
      pid_DATA0 = !dpid; pid_DATA1 = dpid;
      step();
      pid_DATA0 = 0; pid_DATA1 = 0;
      step(int'($urandom_range(0, 4)));
      rx_data_done = 1; crc16_err = err;
      step();
      rx_data_done = 0; crc16_err = 0;
    end
    if (exp_tx) begin
      n = 0;
      while (!tx_data_req && n < 10) begin step(); n++; end
      chk("tx_data_req", 32'(tx_data_req), 32'(1));
      chk("tx_data_pid", 32'(tx_data_pid), 32'(exp_tpid));
      step(2);
      tx_data_done = 1;
      step();
      tx_data_done = 0;
      chk("tx_data_req drop", 32'(tx_data_req), 32'(0));
      if (ack) begin
        step(int'($urandom_range(0, 5)));
        token_valid = 1; pid_ACK = 1;
        step();
        clear_tok();
      end else begin
        n = 0;
        while (!to_err && n < 80) begin step(); n++; end
      end
    end
    if (exp_hs != H_NONE) begin
      n = 0;
      while (!hs_req && n < 10) begin step(); n++; end
      chk("hs_req", 32'(hs_req), 32'(1));
      chk("hs_pid", 32'(hs_pid), 32'(exp_hs));
      hs_ack = 1;
      step();
      hs_ack = 0;
      chk("hs_req drop", 32'(hs_req), 32'(0));
    end else begin
      step(3);
      chk("no hs_req", 32'(hs_req), 32'(0));
      chk("no tx_data_req", 32'(tx_data_req), 32'(0));
    end
    step(2);
    chk("rx_commit pulses", 32'(cnt_rxc - rxc0), 32'(exp_rxc));
    chk("tx_commit pulses", 32'(cnt_txc - txc0), 32'(exp_txc));
    chk("to_err pulses", 32'(cnt_to - to0), 32'(exp_to));
    chk("sof_det pulses", 32'(cnt_sof - sof0), 32'((kind == K_SOF) ? 1 : 0));
    chk("toggle", 32'(toggle), 32'(exp_tgl));
  endtask

  typedef struct {
    int kind; logic [3:0] ep; logic stall, rdy, dpid, err, ack;
    int hs; logic tx, tpid; int rxc, txc, to; logic [15:0] tgl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit early;
    rst = 0; clear_tok();
    pid_DATA0 = 0; pid_DATA1 = 0; rx_data_done = 0; crc16_err = 0; seq_err = 0;
    token_fadr = 0; token_endp = 0; func_adr = 7'h05; ep_en = 16'h7FFF;
    ep_stall = 0; ep_buf_rdy = 0; ep_toggle_clr = 0; hs_ack = 0; tx_data_done = 0;

    //        kind     ep     st    rdy   dpid  err   ack   hs      tx    tpid rxc txc to tgl
    tbl.push_back('{K_OUT,   4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_ACK,  1'b0, 1'b0, 1, 0, 0, 16'h0004});
    tbl.push_back('{K_OUT,   4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_ACK,  1'b0, 1'b0, 0, 0, 0, 16'h0004});
    tbl.push_back('{K_IN,    4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H_STL,  1'b0, 1'b0, 0, 0, 0, 16'h0004});
    tbl.push_back('{K_IN,    4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, H_NAK,  1'b0, 1'b0, 0, 0, 0, 16'h0004});
    tbl.push_back('{K_OUT,   4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_ACK,  1'b0, 1'b0, 1, 0, 0, 16'h0006});
    tbl.push_back('{K_IN,    4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, H_NONE, 1'b1, 1'b1, 0, 1, 0, 16'h0004});
    tbl.push_back('{K_OUT,   4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_ACK,  1'b0, 1'b0, 1, 0, 0, 16'h0006});
    tbl.push_back('{K_IN,    4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_NONE, 1'b1, 1'b1, 0, 0, 1, 16'h0006});
    tbl.push_back('{K_SETUP, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, H_NONE, 1'b0, 1'b0, 0, 0, 0, 16'h0006});
    tbl.push_back('{K_SETUP, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, H_ACK,  1'b0, 1'b0, 1, 0, 0, 16'h0007});
    tbl.push_back('{K_BADADR,4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_NONE, 1'b0, 1'b0, 0, 0, 0, 16'h0007});
    tbl.push_back('{K_CRC5,  4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_NONE, 1'b0, 1'b0, 0, 0, 0, 16'h0007});
    tbl.push_back('{K_PING,  4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_ACK,  1'b0, 1'b0, 0, 0, 0, 16'h0007});
    tbl.push_back('{K_PING,  4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, H_NAK,  1'b0, 1'b0, 0, 0, 0, 16'h0007});
    tbl.push_back('{K_PING,  4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H_STL,  1'b0, 1'b0, 0, 0, 0, 16'h0007});
    tbl.push_back('{K_OUT,   4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, H_STL,  1'b0, 1'b0, 0, 0, 0, 16'h0007});
    tbl.push_back('{K_OUT,   4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, H_NAK,  1'b0, 1'b0, 0, 0, 0, 16'h0007});
    tbl.push_back('{K_OUT,   4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, H_ACK,  1'b0, 1'b0, 1, 0, 0, 16'h0003});
    tbl.push_back('{K_OUT,   4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, H_ACK,  1'b0, 1'b0, 0, 0, 0, 16'h0003});
    tbl.push_back('{K_SOF,   4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_NONE, 1'b0, 1'b0, 0, 0, 0, 16'h0003});
    tbl.push_back('{K_DIS,   4'd15,1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_NONE, 1'b0, 1'b0, 0, 0, 0, 16'h0003});
    tbl.push_back('{K_CKS,   4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_NONE, 1'b0, 1'b0, 0, 0, 0, 16'h0003});
    tbl.push_back('{K_SETUP, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H_ACK,  1'b0, 1'b0, 1, 0, 0, 16'h0023});
    tbl.push_back('{K_IN,    4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, H_NONE, 1'b1, 1'b1, 0, 1, 0, 16'h0003});
    tbl.push_back('{K_IN,    4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, H_NONE, 1'b1, 1'b0, 0, 1, 0, 16'h0007});

    step(2);
    chk("reset hs_req", 32'(hs_req), 32'(0));
    chk("reset tx_data_req", 32'(tx_data_req), 32'(0));
    chk("reset toggle", 32'(toggle), 32'(0));
    chk("reset ep_sel", 32'(ep_sel), 32'(0));
    chk("reset rx_dma_en", 32'(rx_dma_en), 32'(0));
    rst = 1;
    step();

    foreach (tbl[i])
      run_txn(tbl[i].kind, tbl[i].ep, tbl[i].stall, tbl[i].rdy, tbl[i].dpid, tbl[i].err,
              tbl[i].ack, tbl[i].hs, tbl[i].tx, tbl[i].tpid, tbl[i].rxc, tbl[i].txc,
              tbl[i].to, tbl[i].tgl);

    // OUT with no data: to_err exactly TO_CYCLES edges after the token edge.
    ep_stall[8] = 0; ep_buf_rdy[8] = 1;
    send_token(K_OUT, 4'd8);
    early = 0;
    for (int k = 1; k < 60; k++) begin step(); early |= to_err; end
    chk("data timeout early", 32'(early), 32'(0));
    step();
    chk("data timeout at limit", 32'(to_err), 32'(1));
    step();
    chk("idle after data timeout", 32'(rx_dma_en), 32'(0));

    // IN ACK on the last allowed cycle is still accepted.
    ep_stall[7] = 0; ep_buf_rdy[7] = 1;
    send_token(K_IN, 4'd7);
    chk("late ack tx_data_pid", 32'(tx_data_pid), 32'(0));
    tx_data_done = 1; step(); tx_data_done = 0;
    step(59);
    token_valid = 1; pid_ACK = 1;
    step();
    clear_tok();
    chk("late ack tx_commit", 32'(tx_commit), 32'(1));
    chk("late ack no to_err", 32'(to_err), 32'(0));
    step();
    chk("late ack toggle", 32'(toggle), 32'(16'h0087));

    // Token arriving with hs_ack is ignored.
    ep_stall[4] = 0; ep_buf_rdy[4] = 1;
    send_token(K_PING, 4'd4);
    chk("ping hs_pid", 32'(hs_pid), 32'(H_ACK));
    hs_ack = 1; token_valid = 1; pid_IN = 1; token_endp = 4'd4; token_fadr = 7'h05;
    step();
    hs_ack = 0; clear_tok();
    chk("hs_ack drop", 32'(hs_req), 32'(0));
    step(3);
    chk("token with hs_ack ignored", 32'({hs_req, tx_data_req}), 32'(0));

    // Toggle clear beats the SETUP set on the same edge.
    send_token(K_SETUP, 4'd9);
    pid_DATA0 = 1; step(); pid_DATA0 = 0;
    rx_data_done = 1; ep_toggle_clr = 16'h0200;
    step();
    rx_data_done = 0; ep_toggle_clr = 0;
    chk("setup vs clr hs_req", 32'(hs_req), 32'(1));
    chk("setup vs clr toggle", 32'(toggle), 32'(16'h0087));
    hs_ack = 1; step(); hs_ack = 0;
    ep_toggle_clr = 16'h0080; step(); ep_toggle_clr = 0;
    chk("toggle_clr ep7", 32'(toggle), 32'(16'h0007));

    // Reset in the middle of TX_DATA.
    ep_stall[0] = 0; ep_buf_rdy[0] = 1;
    send_token(K_IN, 4'd0);
    chk("pre-reset tx_data_pid", 32'(tx_data_pid), 32'(1));
    rst = 0; step();
    chk("mid reset tx_data_req", 32'(tx_data_req), 32'(0));
    chk("mid reset toggle", 32'(toggle), 32'(0));
    chk("mid reset ep_sel", 32'(ep_sel), 32'(0));
    rst = 1; step();
    mt = 16'h0000;

    // Randomized transactions against the transaction-level model.
    for (int t = 0; t < 150; t++) begin
      int kind, hs, rxc, txc, to;
      logic [3:0] ep;
      logic s, r, d, e, a, tx, tp;
      logic [15:0] msk;
      if ($urandom_range(0, 9) == 0) begin
        msk = 16'($urandom);
        ep_toggle_clr = msk; step(); ep_toggle_clr = 0;
        mt &= ~msk;
        chk("random toggle_clr", 32'(toggle), 32'(mt));
      end
      kind = int'($urandom_range(0, 8));
      ep = (kind == K_DIS) ? 4'd15 : 4'($urandom_range(0, 14));
      s = ($urandom_range(0, 4) == 0); r = ($urandom_range(0, 3) != 0);
      d = 1'($urandom); e = ($urandom_range(0, 5) == 0); a = ($urandom_range(0, 5) != 0);
      ep_stall = 16'($urandom); ep_buf_rdy = 16'($urandom);
      hs = H_NONE; tx = 0; tp = 0; rxc = 0; txc = 0; to = 0;
      case (kind)
        K_OUT: if (!e) begin
          if (s) hs = H_STL;
          else if (!r) hs = H_NAK;
          else begin
            hs = H_ACK;
            if (d == mt[ep]) begin rxc = 1; mt[ep] = ~mt[ep]; end
          end
        end
        K_SETUP: if (!e) begin hs = H_ACK; rxc = 1; mt[ep] = 1'b1; end
        K_IN: begin
          if (s) hs = H_STL;
          else if (!r) hs = H_NAK;
          else begin
            tx = 1; tp = mt[ep];
            if (a) begin txc = 1; mt[ep] = ~mt[ep]; end else to = 1;
          end
        end
        K_PING: hs = s ? H_STL : (r ? H_ACK : H_NAK);
        default: hs = H_NONE;
      endcase
      run_txn(kind, ep, s, r, d, e, a, hs, tx, tp, rxc, txc, to, mt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
